// File: rtl/ysyx_23060208_lsu_pkg.sv
// Shared encodings for the LSU: access sizes, FSM states, AXI response codes
// and the latched-op record.
package ysyx_23060208_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RD_A  = 3'd1;
  localparam state_t ST_RD_R  = 3'd2;
  localparam state_t ST_WR_AW = 3'd3;
  localparam state_t ST_WR_B  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } op_t;

  // Conflicting ren/wen is folded into the misalign error path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane,
                                         input logic ren, input logic wen);
    return (size == 2'd3) || (size == SIZE_H && lane[0]) ||
           (size == SIZE_W && lane != 2'b00) || (ren && wen);
  endfunction

endpackage

// File: rtl/ysyx_23060208_lsu_align.sv
// Byte-lane steering: store data replication + strobes, and load lane
// select with sign/zero extension.
module ysyx_23060208_lsu_align
  import ysyx_23060208_lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;
  assign w_shifted = i_rdata >> {i_lane, 3'b000};

  always_comb begin
    o_wdata = i_wdata;
    o_wstrb = 4'b1111;
    o_rdata = w_shifted;
    case (i_size)
      SIZE_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_wstrb = 4'b0001 << i_lane;
        o_rdata = i_unsigned ? {24'd0, w_shifted[7:0]}
                             : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      SIZE_H: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_wstrb = 4'b0011 << i_lane;
        o_rdata = i_unsigned ? {16'd0, w_shifted[15:0]}
                             : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: one EXU memory op at a time, executed as an AXI4-Lite
// master, with the result held for WBU until accepted.
module ysyx_23060208_lsu
  import ysyx_23060208_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic                  i_in_ren,
  input  logic                  i_in_wen,
  input  logic [1:0]            i_in_size,
  input  logic                  i_in_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_in_addr,
  input  logic [DATA_WIDTH-1:0] i_in_wdata,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_rdata,
  output logic                  o_out_err,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [3:0]            o_wstrb,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  input  logic [1:0]            i_bresp,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rvalid,
  output logic                  o_rready
);

  state_t                r_state;
  op_t                   r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_aw_done;
  logic                  r_w_done;

  logic                  w_misalign;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic [31:0]           w_ld_data;

  assign w_misalign = is_misaligned(i_in_size, i_in_addr[1:0], i_in_ren, i_in_wen);
  assign w_aw_done  = r_aw_done || i_awready;
  assign w_w_done   = r_w_done || i_wready;

  ysyx_23060208_lsu_align u_align (
    .i_size     (r_op.size),
    .i_unsigned (r_op.uns),
    .i_lane     (r_op.lane),
    .i_wdata    (r_op.wdata),
    .i_rdata    (i_rdata),
    .o_wdata    (o_wdata),
    .o_wstrb    (o_wstrb),
    .o_rdata    (w_ld_data)
  );

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_out_rdata = r_rdata;
  assign o_out_err   = r_err;
  assign o_araddr    = r_addr;
  assign o_awaddr    = r_addr;
  assign o_arvalid   = (r_state == ST_RD_A);
  assign o_rready    = (r_state == ST_RD_R);
  assign o_awvalid   = (r_state == ST_WR_AW) && !r_aw_done;
  assign o_wvalid    = (r_state == ST_WR_AW) && !r_w_done;
  assign o_bready    = (r_state == ST_WR_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_addr    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_in_valid) begin
          r_op      <= '{size: i_in_size, uns: i_in_unsigned,
                         lane: i_in_addr[1:0], wdata: i_in_wdata};
          r_addr    <= {i_in_addr[ADDR_WIDTH-1:2], 2'b00};
          r_rdata   <= '0;
          r_err     <= w_misalign;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (w_misalign || (!i_in_ren && !i_in_wen)) r_state <= ST_DONE;
          else if (i_in_ren)                          r_state <= ST_RD_A;
          else                                        r_state <= ST_WR_AW;
        end
        ST_RD_A: if (i_arready) r_state <= ST_RD_R;
        ST_RD_R: if (i_rvalid) begin
          // A failed read returns zero rather than whatever the slave drove.
          r_rdata <= (i_rresp == RESP_OKAY) ? w_ld_data : '0;
          r_err   <= (i_rresp != RESP_OKAY);
          r_state <= ST_DONE;
        end
        ST_WR_AW: begin
          r_aw_done <= w_aw_done;
          r_w_done  <= w_w_done;
          if (w_aw_done && w_w_done) r_state <= ST_WR_B;
        end
        ST_WR_B: if (i_bvalid) begin
          r_err   <= (i_bresp != RESP_OKAY);
          r_state <= ST_DONE;
        end
        ST_DONE: if (i_out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// Directed bench for the LSU: table of single ops against a zero-wait slave,
// plus hand sequences for split AW/W handshakes, WBU backpressure and reset.
module tb_ysyx_23060208_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_ren, in_wen, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_23060208_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_ren(in_ren), .i_in_wen(in_wen),
    .i_in_size(in_size), .i_in_unsigned(in_unsigned), .i_in_addr(in_addr),
    .i_in_wdata(in_wdata), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_rdata(out_rdata), .o_out_err(out_err),
    .o_awaddr(awaddr), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_araddr(araddr), .o_arvalid(arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(rready)
  );

  typedef struct {
    logic        ren, wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wd, bus_rdata;
    logic [1:0]  resp;
    int          bus;        // 0 none, 1 read, 2 write
    logic [31:0] exp_baddr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ren, logic wen, logic [1:0] size, logic uns,
                              logic [31:0] addr, logic [31:0] wd, logic [31:0] brd,
                              logic [1:0] resp, int bus, logic [31:0] baddr,
                              logic [31:0] ewd, logic [3:0] estrb, logic [31:0] erd,
                              logic eerr, int lat);
    vec_t v;
    v.ren = ren; v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wd = wd;
    v.bus_rdata = brd; v.resp = resp; v.bus = bus; v.exp_baddr = baddr;
    v.exp_wdata = ewd; v.exp_wstrb = estrb; v.exp_rdata = erd; v.exp_err = eerr;
    v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; out_ready = 0;
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    in_ren = ren; in_wen = wen; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wd; in_valid = 1;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat = 0;
    bit done = 0, saw_ar = 0, saw_aw = 0, saw_w = 0;
    issue(v.ren, v.wen, v.size, v.uns, v.addr, v.wd);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      arready = arvalid; rvalid = rready; rdata = v.bus_rdata; rresp = v.resp;
      awready = awvalid; wready = wvalid; bvalid = bready; bresp = v.resp;
      out_ready = out_valid;
      if (arvalid && !saw_ar) begin
        saw_ar = 1;
        chk($sformatf("v%0d_araddr", idx), araddr, v.exp_baddr);
      end
      if (awvalid && !saw_aw) begin
        saw_aw = 1;
        chk($sformatf("v%0d_awaddr", idx), awaddr, v.exp_baddr);
      end
      if (wvalid && !saw_w) begin
        saw_w = 1;
        chk($sformatf("v%0d_wdata", idx), wdata, v.exp_wdata);
        chk($sformatf("v%0d_wstrb", idx), {28'd0, wstrb}, {28'd0, v.exp_wstrb});
      end
      if (out_valid) begin
        done = 1;
        chk($sformatf("v%0d_rdata", idx), out_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), {31'd0, out_err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
      end
    end
    if (!done) chk($sformatf("v%0d_timeout", idx), 32'd0, 32'd1);
    @(posedge clk); #1;
    slave_idle();
    chk($sformatf("v%0d_read_bus", idx), {31'd0, saw_ar}, {31'd0, v.bus == 1});
    chk($sformatf("v%0d_write_bus", idx), {31'd0, saw_aw && saw_w}, {31'd0, v.bus == 2});
    chk($sformatf("v%0d_idle_after", idx), {30'd0, in_ready, out_valid}, 32'b10);
    $display("op %0d ren=%0d wen=%0d size=%0d addr=%h -> rdata=%h err=%0d lat=%0d",
             idx, v.ren, v.wen, v.size, v.addr, out_rdata, out_err, lat);
  endtask

  initial begin
    //            ren wen size uns addr          wdata         bus_rdata     rsp bus baddr         exp_wdata     strb     exp_rdata     err lat
    vecs.push_back(mk(1, 0, 2'd0, 0, 32'h80000003, 32'h0,        32'h80FF1234, 0, 1, 32'h80000000, 32'h0,        4'b0000, 32'hFFFFFF80, 0, 3));
    vecs.push_back(mk(1, 0, 2'd1, 1, 32'h80000002, 32'h0,        32'hBEEF0000, 0, 1, 32'h80000000, 32'h0,        4'b0000, 32'h0000BEEF, 0, 3));
    vecs.push_back(mk(1, 0, 2'd1, 0, 32'h80000002, 32'h0,        32'hBEEF0000, 0, 1, 32'h80000000, 32'h0,        4'b0000, 32'hFFFFBEEF, 0, 3));
    vecs.push_back(mk(1, 0, 2'd0, 1, 32'h80000001, 32'h0,        32'h80FF1234, 0, 1, 32'h80000000, 32'h0,        4'b0000, 32'h00000012, 0, 3));
    vecs.push_back(mk(1, 0, 2'd2, 0, 32'h80000008, 32'h0,        32'hDEADBEEF, 0, 1, 32'h80000008, 32'h0,        4'b0000, 32'hDEADBEEF, 0, 3));
    vecs.push_back(mk(1, 0, 2'd0, 0, 32'h80000002, 32'h0,        32'h807F0000, 0, 1, 32'h80000000, 32'h0,        4'b0000, 32'h0000007F, 0, 3));
    vecs.push_back(mk(0, 1, 2'd1, 0, 32'h80000006, 32'h00001234, 32'h0,        0, 2, 32'h80000004, 32'h12341234, 4'b1100, 32'h0,        0, 3));
    vecs.push_back(mk(0, 1, 2'd0, 0, 32'h80000001, 32'hFFFFFFAB, 32'h0,        0, 2, 32'h80000000, 32'hABABABAB, 4'b0010, 32'h0,        0, 3));
    vecs.push_back(mk(0, 1, 2'd2, 0, 32'h8000000C, 32'hCAFEF00D, 32'h0,        0, 2, 32'h8000000C, 32'hCAFEF00D, 4'b1111, 32'h0,        0, 3));
    vecs.push_back(mk(1, 0, 2'd2, 0, 32'h80000002, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 1));
    vecs.push_back(mk(1, 0, 2'd2, 0, 32'h80000010, 32'h0,        32'h11111111, 2, 1, 32'h80000010, 32'h0,        4'b0000, 32'h0,        1, 3));
    vecs.push_back(mk(0, 1, 2'd2, 0, 32'h80000014, 32'h55AA55AA, 32'h0,        2, 2, 32'h80000014, 32'h55AA55AA, 4'b1111, 32'h0,        1, 3));
    vecs.push_back(mk(1, 0, 2'd3, 0, 32'h80000000, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 1));
    vecs.push_back(mk(1, 1, 2'd2, 0, 32'h80000000, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 1));
    vecs.push_back(mk(0, 0, 2'd2, 0, 32'h80000000, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 2'd1, 1, 32'h80000001, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 1));
    vecs.push_back(mk(0, 1, 2'd1, 0, 32'h80000003, 32'h00001234, 32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 1));

    rst_n = 0; in_valid = 0; in_ren = 0; in_wen = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_wdata = 0;
    slave_idle();
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_valids", {26'd0, arvalid, awvalid, wvalid, rready, bready, out_valid}, 32'd0);
    chk("reset_out", {out_rdata[31:1], out_rdata[0] | out_err}, 32'd0);
    rst_n = 1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Store where W completes three cycles before AW, then 5 cycles of WBU stall.
    issue(0, 1, 2'd2, 0, 32'h80000020, 32'h01020304);
    @(negedge clk);
    chk("split_first_valids", {30'd0, awvalid, wvalid}, 32'b11);
    wready = 1;
    @(posedge clk); #1; wready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("split_aw_held_%0d", k), {30'd0, awvalid, wvalid}, 32'b10);
      chk($sformatf("split_awaddr_%0d", k), awaddr, 32'h80000020);
      if (k == 2) awready = 1;
    end
    @(posedge clk); #1; awready = 0;
    @(negedge clk);
    chk("split_b_phase", {29'd0, awvalid, wvalid, bready}, 32'b001);
    bvalid = 1; bresp = 0;
    @(posedge clk); #1; bvalid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_%0d", k), {29'd0, out_valid, in_ready, bready}, 32'b100);
      chk($sformatf("stall_out_%0d", k), {out_rdata[31:1], out_rdata[0] | out_err}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk("stall_release", {30'd0, out_valid, in_ready}, 32'b01);
    $display("split store: single B handshake, released after stall");

    // Reset while waiting on the R channel, then stray R beats while idle.
    issue(1, 0, 2'd2, 0, 32'h80000040, 32'h0);
    @(negedge clk);
    arready = 1;
    @(posedge clk); #1; arready = 0;
    @(negedge clk);
    chk("rst_pre_rready", {31'd0, rready}, 32'd1);
    rst_n = 0;
    #1;
    chk("rst_mid_valids", {26'd0, arvalid, awvalid, wvalid, rready, bready, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1;
    rvalid = 1; rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    chk("stray_r_ignored", {29'd0, out_valid, in_ready, rready}, 32'b010);
    slave_idle();
    $display("reset mid-read: bus released, stray R ignored");
    run_vec(99, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
